// File: rtl/fileira_pkg.sv
// Shared types and helpers for the enemy-row controller: state encoding, row geometry
// constants and alive-mask helpers (lowest/highest alive index, popcount).
package fileira_pkg;

    localparam int NUM_INIMIGOS = 5;
    localparam int COORD_W      = 10;
    localparam logic [COORD_W-1:0] X_OCULTO = 10'd1023;

    typedef enum logic [2:0] {
        OCIOSO,
        MARCHA,
        DESCE,
        CHEGOU_ST,
        LIMPO_ST
    } estado_t;

    function automatic logic [2:0] indice_lo(input logic [NUM_INIMIGOS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_INIMIGOS - 1; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] indice_hi(input logic [NUM_INIMIGOS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_INIMIGOS; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic int contar_vivos(input logic [NUM_INIMIGOS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_INIMIGOS; i++)
            n += int'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/controle_fileira_divisor_quadros.sv
// Frame-tick divider: emits a move tick on the FRAME_TICK that completes a period of limite_i ticks.
// Combinational move_o, one-cycle pulse; counter saturates gracefully if the limit shrinks below it.
module divisor_quadros #(
    parameter int W = 3
) (
    input  logic         CLK_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         tick_i,
    input  logic [W-1:0] limite_i,
    output logic         move_o
);

    logic [W-1:0] cnt_q;

    // >= rather than == so a limit that drops below the current count still fires next tick
    assign move_o = en_i && tick_i && (cnt_q >= limite_i - W'(1));

    always_ff @(posedge CLK_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && tick_i) begin
            cnt_q <= move_o ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/controle_fileira.sv
// Motion and alive-state controller for a row of five enemies; drives packed X/Y object buses.
// All outputs registered (event at t visible at t+1). Optional SPEEDUP_EN shortens the move period as enemies die.
module controle_fileira
    import fileira_pkg::*;
#(
    parameter int X_INICIAL   = 40,
    parameter int Y_INICIAL   = 40,
    parameter int ESPACO      = 60,
    parameter int LARGURA     = 40,
    parameter int ALTURA      = 40,
    parameter int PASSO_X     = 4,
    parameter int PASSO_Y     = 20,
    parameter int X_MAX       = 640,
    parameter int Y_LIMITE    = 440,
    parameter int DIV_QUADROS = 4
) (
    input  logic                              CLK_i,
    input  logic                              reset_i,
    input  logic                              FRAME_TICK_i,
    input  logic                              START_i,
    input  logic                              KILL_i,
    input  logic [2:0]                        KILL_IDX_i,
    output logic [NUM_INIMIGOS*COORD_W-1:0]   X_OBJETO_o,
    output logic [NUM_INIMIGOS*COORD_W-1:0]   Y_OBJETO_o,
    output logic [NUM_INIMIGOS-1:0]           VIVOS_o,
    output logic                              CHEGOU_o,
    output logic                              LIMPO_o
);

    localparam int CNT_W = $clog2(DIV_QUADROS + 1);

    if (X_INICIAL + 4 * ESPACO + LARGURA > X_MAX) begin : g_geometria_invalida
        $error("controle_fileira: initial row does not fit inside X_MAX");
    end

    estado_t                            state_q, state_d;
    logic [COORD_W-1:0]                 base_x_q, base_x_d, base_y_q, base_y_d;
    logic [NUM_INIMIGOS-1:0]            vivos_q, vivos_d;
    logic                               dir_q, dir_d;
    logic [NUM_INIMIGOS*COORD_W-1:0]    x_obj_q, x_obj_d, y_obj_q, y_obj_d;
    logic                               chegou_q, limpo_q;
    logic [CNT_W-1:0]                   limite;
    logic                               move, ativo, kill_ok;
    logic [10:0]                        borda_esq, borda_dir;

    assign ativo = (state_q == MARCHA) || (state_q == DESCE);

`ifdef SPEEDUP_EN
    always_comb begin
        int lim;
        lim = DIV_QUADROS - (NUM_INIMIGOS - contar_vivos(vivos_q));
        if (lim < 1) lim = 1;
        limite = CNT_W'(lim);
    end
`else
    assign limite = CNT_W'(DIV_QUADROS);
`endif

    divisor_quadros #(.W(CNT_W)) u_divisor (
        .CLK_i    (CLK_i),
        .reset_i  (reset_i),
        .clr_i    (START_i),
        .en_i     (ativo),
        .tick_i   (FRAME_TICK_i),
        .limite_i (limite),
        .move_o   (move)
    );

    // Edges come from the registered mask, so a same-cycle kill does not affect this move
    assign borda_esq = {1'b0, base_x_q} + 11'(indice_lo(vivos_q)) * 11'(ESPACO);
    assign borda_dir = {1'b0, base_x_q} + 11'(indice_hi(vivos_q)) * 11'(ESPACO) + 11'(LARGURA);
    assign kill_ok   = ativo && KILL_i && (KILL_IDX_i < 3'd5) && vivos_q[KILL_IDX_i];

    always_comb begin
        state_d  = state_q;
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        vivos_d  = vivos_q;
        dir_d    = dir_q;
        if (START_i) begin
            state_d  = MARCHA;
            base_x_d = COORD_W'(X_INICIAL);
            base_y_d = COORD_W'(Y_INICIAL);
            vivos_d  = '1;
            dir_d    = 1'b0;
        end else begin
            if (kill_ok)
                vivos_d = vivos_q & ~(NUM_INIMIGOS'(1) << KILL_IDX_i);
            if (kill_ok && (vivos_d == '0)) begin
                state_d = LIMPO_ST;
            end else if (move && (state_q == MARCHA)) begin
                if (!dir_q) begin
                    if (borda_dir + 11'(PASSO_X) <= 11'(X_MAX)) base_x_d = base_x_q + COORD_W'(PASSO_X);
                    else                                         state_d  = DESCE;
                end else begin
                    if (borda_esq >= 11'(PASSO_X)) base_x_d = base_x_q - COORD_W'(PASSO_X);
                    else                           state_d  = DESCE;
                end
            end else if (move && (state_q == DESCE)) begin
                if ({1'b0, base_y_q} + 11'(PASSO_Y + ALTURA) > 11'(Y_LIMITE)) begin
                    state_d = CHEGOU_ST;
                end else begin
                    base_y_d = base_y_q + COORD_W'(PASSO_Y);
                    dir_d    = ~dir_q;
                    state_d  = MARCHA;
                end
            end
        end
    end

    always_comb begin
        x_obj_d = {NUM_INIMIGOS{X_OCULTO}};
        y_obj_d = {NUM_INIMIGOS{X_OCULTO}};
        for (int i = 0; i < NUM_INIMIGOS; i++) begin
            if ((state_d == MARCHA || state_d == DESCE || state_d == CHEGOU_ST) && vivos_d[i]) begin
                x_obj_d[i*COORD_W +: COORD_W] = base_x_d + COORD_W'(i * ESPACO);
                y_obj_d[i*COORD_W +: COORD_W] = base_y_d;
            end
        end
    end

    always_ff @(posedge CLK_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= OCIOSO;
            base_x_q <= '0;
            base_y_q <= '0;
            vivos_q  <= '0;
            dir_q    <= 1'b0;
            x_obj_q  <= {NUM_INIMIGOS{X_OCULTO}};
            y_obj_q  <= {NUM_INIMIGOS{X_OCULTO}};
            chegou_q <= 1'b0;
            limpo_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            vivos_q  <= vivos_d;
            dir_q    <= dir_d;
            x_obj_q  <= x_obj_d;
            y_obj_q  <= y_obj_d;
            chegou_q <= (state_d == CHEGOU_ST);
            limpo_q  <= (state_d == LIMPO_ST);
        end
    end

    assign X_OBJETO_o = x_obj_q;
    assign Y_OBJETO_o = y_obj_q;
    assign VIVOS_o    = vivos_q;
    assign CHEGOU_o   = chegou_q;
    assign LIMPO_o    = limpo_q;

endmodule

// File: tb/tb_controle_fileira.sv
// Directed bench for controle_fileira (default build, fixed divider of 4 frame ticks per move).
module tb_controle_fileira;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        start;
    logic        kill;
    logic [2:0]  kill_idx;
    logic [49:0] x_obj, y_obj;
    logic [4:0]  vivos;
    logic        chegou, limpo;

    int n_checks = 0;
    int n_errors = 0;

    logic [49:0] x_ini, todos_ocultos, y_40;

    controle_fileira dut (
        .CLK_i        (clk),
        .reset_i      (rst_n),
        .FRAME_TICK_i (frame_tick),
        .START_i      (start),
        .KILL_i       (kill),
        .KILL_IDX_i   (kill_idx),
        .X_OBJETO_o   (x_obj),
        .Y_OBJETO_o   (y_obj),
        .VIVOS_o      (vivos),
        .CHEGOU_o     (chegou),
        .LIMPO_o      (limpo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] fld(input logic [49:0] bus, input int i);
        return bus[i*10 +: 10];
    endfunction

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_kill(input logic [2:0] idx);
        kill     = 1'b1;
        kill_idx = idx;
        @(negedge clk);
        kill     = 1'b0;
    endtask

    initial begin
        int k;
        x_ini         = {10'd280, 10'd220, 10'd160, 10'd100, 10'd40};
        todos_ocultos = {5{10'd1023}};
        y_40          = {5{10'd40}};
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; kill = 1'b0; kill_idx = 3'd0;
        repeat (3) @(negedge clk);

        check_val("rst_x", 64'(x_obj), 64'(todos_ocultos));
        check_val("rst_y", 64'(y_obj), 64'(todos_ocultos));
        check_val("rst_vivos", 64'(vivos), 64'h0);
        check_val("rst_flags", 64'({chegou, limpo}), 64'h0);

        rst_n = 1'b1;
        @(negedge clk);
        ticks(8);
        check_val("ocioso_x", 64'(x_obj), 64'(todos_ocultos));

        do_start();
        check_val("start_x", 64'(x_obj), 64'(x_ini));
        check_val("start_y", 64'(y_obj), 64'(y_40));
        check_val("start_vivos", 64'(vivos), 64'h1f);
        check_val("start_flags", 64'({chegou, limpo}), 64'h0);

        ticks(3);
        check_val("div_3ticks", 64'(fld(x_obj, 0)), 64'd40);
        ticks(1);
        check_val("div_4ticks", 64'(fld(x_obj, 0)), 64'd44);

        ticks(316);
        check_val("right_edge_x0", 64'(fld(x_obj, 0)), 64'd360);
        check_val("right_edge_x4", 64'(fld(x_obj, 4)), 64'd600);
        ticks(4);
        check_val("desce_x", 64'(fld(x_obj, 0)), 64'd360);
        check_val("desce_y", 64'(fld(y_obj, 0)), 64'd40);
        ticks(4);
        check_val("desce_y60", 64'(fld(y_obj, 2)), 64'd60);
        check_val("desce_x_hold", 64'(fld(x_obj, 0)), 64'd360);
        ticks(4);
        check_val("left_move", 64'(fld(x_obj, 0)), 64'd356);

        // START and KILL together: START wins
        start = 1'b1; kill = 1'b1; kill_idx = 3'd0;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check_val("start_wins", 64'(vivos), 64'h1f);
        do_kill(3'd4);
        check_val("kill4_vivos", 64'(vivos), 64'h0f);
        check_val("kill4_x", 64'(fld(x_obj, 4)), 64'd1023);
        do_kill(3'd3);
        check_val("kill3_x", 64'(fld(x_obj, 3)), 64'd1023);
        check_val("kill3_y", 64'(fld(y_obj, 3)), 64'd1023);
        do_kill(3'd6);
        check_val("kill_invalid", 64'(vivos), 64'h07);
        do_kill(3'd4);
        check_val("kill_dead", 64'(vivos), 64'h07);
        ticks(440);
        check_val("short_row_x0", 64'(fld(x_obj, 0)), 64'd480);
        check_val("short_row_x2", 64'(fld(x_obj, 2)), 64'd600);
        ticks(4);
        check_val("short_desce_x", 64'(fld(x_obj, 0)), 64'd480);
        ticks(4);
        check_val("short_desce_y", 64'(fld(y_obj, 0)), 64'd60);

        do_kill(3'd0);
        do_kill(3'd1);
        check_val("pre_clear_limpo", 64'(limpo), 64'h0);
        do_kill(3'd2);
        check_val("clear_limpo", 64'(limpo), 64'h1);
        check_val("clear_vivos", 64'(vivos), 64'h0);
        check_val("clear_x", 64'(x_obj), 64'(todos_ocultos));
        check_val("clear_y", 64'(y_obj), 64'(todos_ocultos));
        ticks(12);
        check_val("clear_frozen", 64'({x_obj, limpo}), 64'({todos_ocultos, 1'b1}));

        do_start();
        check_val("restart_x", 64'(x_obj), 64'(x_ini));
        check_val("restart_limpo", 64'(limpo), 64'h0);

        k = 0;
        while (fld(y_obj, 0) != 10'd400 && k < 8000) begin
            ticks(1);
            k++;
        end
        check_val("reach_y400", 64'(fld(y_obj, 0)), 64'd400);
        check_val("y400_no_chegou", 64'(chegou), 64'h0);
        k = 0;
        while (!chegou && k < 1000) begin
            ticks(1);
            k++;
        end
        check_val("chegou_set", 64'(chegou), 64'h1);
        check_val("chegou_y", 64'(fld(y_obj, 4)), 64'd400);
        check_val("chegou_x", 64'(fld(x_obj, 0)), 64'd360);
        ticks(12);
        check_val("chegou_frozen", 64'({fld(x_obj, 0), fld(y_obj, 0), chegou}), 64'({10'd360, 10'd400, 1'b1}));

        do_start();
        ticks(8);
        check_val("mid_march_x", 64'(fld(x_obj, 0)), 64'd48);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_x", 64'(x_obj), 64'(todos_ocultos));
        check_val("async_rst_vivos", 64'(vivos), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ticks(8);
        check_val("post_rst_idle", 64'({x_obj, vivos}), 64'({todos_ocultos, 5'h0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
